// File: rtl/pe_psum_acc.sv
// Accumulates per-chunk signed partial sums from the PE adder tree into one dot-product result.
// Result is registered 1 cycle after the last beat's accept; the upstream is stalled while the result is held.
module pe_psum_acc #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psum_vld,
  output logic              psum_rdy,
  input  logic [DATA_W-1:0] psum_data,
  input  logic              psum_last,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_ovf,
  output logic              res_trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              trunc_q, trunc_d;
  logic              psum_rdy_q, psum_rdy_d;
  logic              res_vld_q, res_vld_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_trunc_q, res_trunc_d;

  logic              accept;
  logic              close;
  logic [DATA_W-1:0] sum;
  logic              sum_ovf;

  assign accept  = psum_vld & psum_rdy_q;
  assign sum     = acc_q + psum_data;
  assign sum_ovf = (acc_q[DATA_W-1] == psum_data[DATA_W-1]) &&
                   (sum[DATA_W-1] != acc_q[DATA_W-1]);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator datapath; close marks the beat that ends a transaction
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    close   = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        acc_d   = psum_data;
        cnt_d   = CNT_ONE;
        ovf_d   = 1'b0;
        trunc_d = 1'b0;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + CNT_ONE;
        ovf_d   = ovf_q | sum_ovf;
        trunc_d = 1'b0;
      end
      if (!psum_last && (cnt_d == CNT_MAX)) begin
        trunc_d = 1'b1;
      end
      close = psum_last | trunc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = close ? DONE : ACC;
      ACC:  if (accept && close) state_d = DONE;
      DONE: if (res_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    psum_rdy_d  = (state_d != DONE);
    res_vld_d   = (state_d == DONE);
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    res_trunc_d = res_trunc_q;
    if (close) begin
      res_data_d  = acc_d;
      res_cnt_d   = cnt_d;
      res_ovf_d   = ovf_d;
      res_trunc_d = trunc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      trunc_q     <= 1'b0;
      psum_rdy_q  <= 1'b0;
      res_vld_q   <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_trunc_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      trunc_q     <= trunc_d;
      psum_rdy_q  <= psum_rdy_d;
      res_vld_q   <= res_vld_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  assign psum_rdy  = psum_rdy_q;
  assign res_vld   = res_vld_q;
  assign res_data  = res_data_q;
  assign res_cnt   = res_cnt_q;
  assign res_ovf   = res_ovf_q;
  assign res_trunc = res_trunc_q;

endmodule

// File: tb/tb_pe_psum_acc.sv
// Directed bench for pe_psum_acc: default instance plus a CNT_W=2 instance for the counter limit.
module tb_pe_psum_acc;

  logic        clk;
  logic        rst_n;
  logic        psum_vld;
  logic        psum_vld2;
  logic [31:0] psum_data;
  logic        psum_last;
  logic        res_rdy;

  logic        psum_rdy,  res_vld,  res_ovf,  res_trunc;
  logic [31:0] res_data;
  logic [7:0]  res_cnt;
  logic        psum_rdy2, res_vld2, res_ovf2, res_trunc2;
  logic [31:0] res_data2;
  logic [1:0]  res_cnt2;

  int vectors = 0;
  int miscompares = 0;

  pe_psum_acc #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .psum_vld(psum_vld), .psum_rdy(psum_rdy), .psum_data(psum_data), .psum_last(psum_last),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_cnt(res_cnt),
    .res_ovf(res_ovf), .res_trunc(res_trunc)
  );

  pe_psum_acc #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .psum_vld(psum_vld2), .psum_rdy(psum_rdy2), .psum_data(psum_data), .psum_last(psum_last),
    .res_vld(res_vld2), .res_rdy(res_rdy), .res_data(res_data2), .res_cnt(res_cnt2),
    .res_ovf(res_ovf2), .res_trunc(res_trunc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a beat to instance sel (0 = default, 1 = CNT_W=2) and return just after its accepting edge
  task automatic send(input bit sel, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    psum_data = d;
    psum_last = l;
    if (sel) psum_vld2 = 1'b1; else psum_vld = 1'b1;
    while (((sel ? psum_rdy2 : psum_rdy) == 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("beat_accept_timeout", 32'(sel ? psum_rdy2 : psum_rdy), 32'd1);
    @(posedge clk);
    #1;
    psum_vld  = 1'b0;
    psum_vld2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psum_vld = 1'b0; psum_vld2 = 1'b0;
    psum_data = 32'h0; psum_last = 1'b0; res_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_psum_rdy",  32'(psum_rdy),  32'd0);
    chk("rst_res_vld",   32'(res_vld),   32'd0);
    chk("rst_res_data",  res_data,       32'd0);
    chk("rst_res_cnt",   32'(res_cnt),   32'd0);
    chk("rst_res_ovf",   32'(res_ovf),   32'd0);
    chk("rst_res_trunc", 32'(res_trunc), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", 32'(psum_rdy), 32'd1);

    // Four-beat transaction: 10 - 3 + 7 + 100 = 114
    send(0, 32'd10, 1'b0);
    send(0, 32'hFFFF_FFFD, 1'b0);
    send(0, 32'd7, 1'b0);
    send(0, 32'd100, 1'b1);
    chk("t4_res_vld",   32'(res_vld),   32'd1);
    chk("t4_psum_rdy",  32'(psum_rdy),  32'd0);
    chk("t4_res_data",  res_data,       32'd114);
    chk("t4_res_cnt",   32'(res_cnt),   32'd4);
    chk("t4_res_ovf",   32'(res_ovf),   32'd0);
    chk("t4_res_trunc", 32'(res_trunc), 32'd0);
    @(posedge clk); #1;
    chk("t4_vld_drop",  32'(res_vld),   32'd0);
    chk("t4_rdy_back",  32'(psum_rdy),  32'd1);
    chk("t4_data_held", res_data,       32'd114);

    // Single beat -10
    send(0, 32'hFFFF_FFF6, 1'b1);
    chk("t1_res_data", res_data,     32'hFFFF_FFF6);
    chk("t1_res_cnt",  32'(res_cnt), 32'd1);
    @(posedge clk); #1;
    chk("t1_rdy_back", 32'(psum_rdy), 32'd1);

    // Signed overflow wraps and stays sticky
    send(0, 32'h7FFF_FFFF, 1'b0);
    send(0, 32'd1, 1'b0);
    send(0, 32'hFFFF_FFFB, 1'b1);
    chk("ovf_res_data", res_data,     32'h7FFF_FFFB);
    chk("ovf_res_cnt",  32'(res_cnt), 32'd3);
    chk("ovf_res_ovf",  32'(res_ovf), 32'd1);
    @(posedge clk); #1;
    chk("ovf_held",     32'(res_ovf), 32'd1);

    // Back-pressure: result held, upstream stalled with a beat pending
    res_rdy = 1'b0;
    send(0, 32'd20, 1'b0);
    send(0, 32'd22, 1'b1);
    chk("bp_ovf_cleared", 32'(res_ovf), 32'd0);
    psum_vld = 1'b1; psum_data = 32'd99; psum_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_psum_rdy", 32'(psum_rdy), 32'd0);
      chk("bp_res_vld",  32'(res_vld),  32'd1);
      chk("bp_res_data", res_data,      32'd42);
      @(posedge clk); #1;
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_vld", 32'(res_vld),  32'd0);
    chk("bp_release_rdy", 32'(psum_rdy), 32'd1);
    @(posedge clk); #1;
    psum_vld = 1'b0;
    chk("bp_next_vld",  32'(res_vld),   32'd1);
    chk("bp_next_data", res_data,       32'd99);
    chk("bp_next_cnt",  32'(res_cnt),   32'd1);
    @(posedge clk); #1;

    // Counter limit on the CNT_W=2 instance
    send(1, 32'd1, 1'b0);
    send(1, 32'd2, 1'b0);
    send(1, 32'd3, 1'b0);
    chk("lim_res_vld",   32'(res_vld2),   32'd1);
    chk("lim_res_data",  res_data2,       32'd6);
    chk("lim_res_cnt",   32'(res_cnt2),   32'd3);
    chk("lim_res_trunc", 32'(res_trunc2), 32'd1);
    send(1, 32'd5, 1'b1);
    chk("lim2_res_data",  res_data2,       32'd5);
    chk("lim2_res_cnt",   32'(res_cnt2),   32'd1);
    chk("lim2_res_trunc", 32'(res_trunc2), 32'd0);
    // Last coinciding with the limit is a normal completion
    send(1, 32'd4, 1'b0);
    send(1, 32'd4, 1'b0);
    send(1, 32'd4, 1'b1);
    chk("limlast_data",  res_data2,       32'd12);
    chk("limlast_cnt",   32'(res_cnt2),   32'd3);
    chk("limlast_trunc", 32'(res_trunc2), 32'd0);
    chk("idle_dut_vld",  32'(res_vld),    32'd0);

    // Reset mid-transaction
    send(0, 32'd8, 1'b0);
    send(0, 32'd9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rdy",  32'(psum_rdy), 32'd0);
    chk("mid_rst_vld",  32'(res_vld),  32'd0);
    chk("mid_rst_data", res_data,      32'd0);
    chk("mid_rst_cnt",  32'(res_cnt),  32'd0);
    rst_n = 1'b1;
    send(0, 32'd42, 1'b1);
    chk("post_rst_vld",  32'(res_vld), 32'd1);
    chk("post_rst_data", res_data,     32'd42);
    chk("post_rst_cnt",  32'(res_cnt), 32'd1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
